video_timing_gen_param: RTL and testbench

//  Parametrised raster timing generator, successor to the fixed 384x264 GX400 timing block.

---
 rtl/video_timing_gen_param.sv | 141 ++++++++++++++
 tb/tb_video_timing_gen_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen_param.sv
// Parametrised raster timing generator: pixel/line counters, blank/sync decode, flip counters,
// frame parity, line-advance strobe and a raster-line interrupt with ack and overrun tracking.
module video_timing_gen_param #(
   parameter int HW         = 9,
   parameter int VW         = 9,
   parameter int H_START    = 128,
   parameter int H_END      = 511,
   parameter int V_START    = 248,
   parameter int V_END      = 511,
   parameter int HBLANK_OFF = 256,
   parameter int HSYNC_ON   = 176,
   parameter int HSYNC_OFF  = 208,
   parameter int VBLANK_ON  = 496,
   parameter int VBLANK_OFF = 272,
   parameter int VSYNC_ON   = 248,
   parameter int VSYNC_OFF  = 256,
   parameter int LINE_ADV   = 176
) (
   input  logic          i_EMU_MCLK,
   input  logic          i_MRST_n,
   input  logic          i_EMU_CLK6MPCEN_n,
   input  logic          i_HFLIP,
   input  logic          i_VFLIP,
   input  logic          i_IRQ_EN,
   input  logic [VW-1:0] i_IRQ_LINE,
   input  logic          i_IRQ_ACK_n,
   output logic [HW-1:0] o_HCNT,
   output logic [VW-1:0] o_VCNT,
   output logic [HW-2:0] o_FLIP_H,
   output logic [VW-2:0] o_FLIP_V,
   output logic          o_HBLANK_n,
   output logic          o_VBLANK_n,
   output logic          o_HSYNC_n,
   output logic          o_VSYNC_n,
   output logic          o_CSYNC_n,
   output logic          o_LINE_STB,
   output logic          o_FRAMEPARITY,
   output logic          o_IRQ_n,
   output logic          o_IRQ_OVR
);

   localparam logic [HW-1:0] H_FIRST  = HW'(H_START);
   localparam logic [HW-1:0] H_LAST   = HW'(H_END);
   localparam logic [HW-1:0] H_PREADV = HW'(LINE_ADV - 1);
   localparam logic [HW-1:0] HB_OFF   = HW'(HBLANK_OFF);
   localparam logic [HW-1:0] HS_ON    = HW'(HSYNC_ON);
   localparam logic [HW-1:0] HS_OFF   = HW'(HSYNC_OFF);
   localparam logic [VW-1:0] V_FIRST  = VW'(V_START);
   localparam logic [VW-1:0] V_LAST   = VW'(V_END);
   localparam logic [VW-1:0] VB_ON    = VW'(VBLANK_ON);
   localparam logic [VW-1:0] VB_OFF   = VW'(VBLANK_OFF);
   localparam logic [VW-1:0] VS_ON    = VW'(VSYNC_ON);
   localparam logic [VW-1:0] VS_OFF   = VW'(VSYNC_OFF);

   function automatic logic hblank_act(input logic [HW-1:0] h);
      return h < HB_OFF;
   endfunction

   function automatic logic hsync_act(input logic [HW-1:0] h);
      return (h >= HS_ON) && (h < HS_OFF);
   endfunction

   function automatic logic vblank_act(input logic [VW-1:0] v);
      return (v >= VB_ON) || (v < VB_OFF);
   endfunction

   function automatic logic vsync_act(input logic [VW-1:0] v);
      return (v >= VS_ON) && (v < VS_OFF);
   endfunction

   logic          pix_en;
   logic          line_adv;
   logic          irq_ack;
   logic          irq_match;
   logic [HW-1:0] hcnt, hcnt_nxt;
   logic [VW-1:0] vcnt, vcnt_nxt;

   assign pix_en   = ~i_EMU_CLK6MPCEN_n;
   assign line_adv = pix_en && (hcnt == H_PREADV);
   assign irq_ack  = pix_en && !i_IRQ_ACK_n;
   assign irq_match = i_IRQ_EN && line_adv && (vcnt_nxt == i_IRQ_LINE)
                      && (i_IRQ_LINE >= V_FIRST) && (i_IRQ_LINE <= V_LAST);

   always_comb begin
      hcnt_nxt = hcnt;
      vcnt_nxt = vcnt;
      if (pix_en)
         hcnt_nxt = (hcnt < H_LAST) ? hcnt + HW'(1) : H_FIRST;
      if (line_adv)
         vcnt_nxt = (vcnt < V_LAST) ? vcnt + VW'(1) : V_FIRST;
   end

   // Decodes are taken from the next-state counters so every pin lines up with o_HCNT/o_VCNT.
   always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
      if (!i_MRST_n) begin
         hcnt          <= H_FIRST;
         vcnt          <= V_FIRST;
         o_FLIP_H      <= H_FIRST[HW-2:0];
         o_FLIP_V      <= V_FIRST[VW-2:0];
         o_HBLANK_n    <= ~hblank_act(H_FIRST);
         o_VBLANK_n    <= ~vblank_act(V_FIRST);
         o_HSYNC_n     <= ~hsync_act(H_FIRST);
         o_VSYNC_n     <= ~vsync_act(V_FIRST);
         o_CSYNC_n     <= ~hsync_act(H_FIRST) ^ vsync_act(V_FIRST);
         o_LINE_STB    <= 1'b0;
         o_FRAMEPARITY <= 1'b0;
         o_IRQ_n       <= 1'b1;
         o_IRQ_OVR     <= 1'b0;
      end else begin
         hcnt       <= hcnt_nxt;
         vcnt       <= vcnt_nxt;
         o_FLIP_H   <= hcnt_nxt[HW-2:0] ^ {(HW-1){i_HFLIP}};
         o_FLIP_V   <= vcnt_nxt[VW-2:0] ^ {(VW-1){i_VFLIP}};
         o_HBLANK_n <= ~hblank_act(hcnt_nxt);
         o_VBLANK_n <= ~vblank_act(vcnt_nxt);
         o_HSYNC_n  <= ~hsync_act(hcnt_nxt);
         o_VSYNC_n  <= ~vsync_act(vcnt_nxt);
         // Serration: hsync is inverted on vsync lines.
         o_CSYNC_n  <= ~hsync_act(hcnt_nxt) ^ vsync_act(vcnt_nxt);
         if (pix_en)
            o_LINE_STB <= line_adv;
         if (line_adv && (vcnt_nxt == VB_ON))
            o_FRAMEPARITY <= ~o_FRAMEPARITY;
         // A match beats a coincident ack; the ack still clears any overrun.
         if (irq_match) begin
            o_IRQ_n <= 1'b0;
            if (irq_ack)
               o_IRQ_OVR <= 1'b0;
            else if (!o_IRQ_n)
               o_IRQ_OVR <= 1'b1;
         end else if (irq_ack) begin
            o_IRQ_n   <= 1'b1;
            o_IRQ_OVR <= 1'b0;
         end
      end
   end

   assign o_HCNT = hcnt;
   assign o_VCNT = vcnt;

endmodule

// File: tb/tb_video_timing_gen_param.sv
// Bench for video_timing_gen_param: a default-geometry instance plus a shrunken raster so whole
// frames fit in the run; expectations come from closed-form enable-count arithmetic.
module tb_video_timing_gen_param;

   localparam int NI = 2;

   typedef struct {
      int hs, he, la, hbo, hson, hsoff, vs, ve, vbon, vboff, vson, vsoff;
   } geo_t;

   logic       clk = 1'b0, rst_n = 1'b0, en_n = 1'b1, hflip = 1'b0, vflip = 1'b0;
   logic       irq_en = 1'b0, ack_n = 1'b1;
   logic [8:0] irq_line [NI];
   logic [8:0] hcnt [NI], vcnt [NI];
   logic [7:0] fh [NI], fv [NI];
   logic       hb_n [NI], vb_n [NI], hs_n [NI], vs_n [NI], cs_n [NI];
   logic       stb [NI], par [NI], irq_n [NI], ovr [NI];

   geo_t G [NI];
   int   n;
   bit   m_irq [NI], m_ovr [NI];
   int   n_total = 0, n_pass = 0, n_fail = 0;

   always #5 clk = ~clk;

   video_timing_gen_param dut_d (
      .i_EMU_MCLK(clk), .i_MRST_n(rst_n), .i_EMU_CLK6MPCEN_n(en_n),
      .i_HFLIP(hflip), .i_VFLIP(vflip), .i_IRQ_EN(irq_en), .i_IRQ_LINE(irq_line[0]),
      .i_IRQ_ACK_n(ack_n), .o_HCNT(hcnt[0]), .o_VCNT(vcnt[0]), .o_FLIP_H(fh[0]),
      .o_FLIP_V(fv[0]), .o_HBLANK_n(hb_n[0]), .o_VBLANK_n(vb_n[0]), .o_HSYNC_n(hs_n[0]),
      .o_VSYNC_n(vs_n[0]), .o_CSYNC_n(cs_n[0]), .o_LINE_STB(stb[0]),
      .o_FRAMEPARITY(par[0]), .o_IRQ_n(irq_n[0]), .o_IRQ_OVR(ovr[0]));

   video_timing_gen_param #(
      .H_START(480), .H_END(511), .LINE_ADV(488), .HBLANK_OFF(496), .HSYNC_ON(488),
      .HSYNC_OFF(492), .V_START(480), .V_END(511), .VBLANK_ON(506), .VBLANK_OFF(484),
      .VSYNC_ON(480), .VSYNC_OFF(482)
   ) dut_s (
      .i_EMU_MCLK(clk), .i_MRST_n(rst_n), .i_EMU_CLK6MPCEN_n(en_n),
      .i_HFLIP(hflip), .i_VFLIP(vflip), .i_IRQ_EN(irq_en), .i_IRQ_LINE(irq_line[1]),
      .i_IRQ_ACK_n(ack_n), .o_HCNT(hcnt[1]), .o_VCNT(vcnt[1]), .o_FLIP_H(fh[1]),
      .o_FLIP_V(fv[1]), .o_HBLANK_n(hb_n[1]), .o_VBLANK_n(vb_n[1]), .o_HSYNC_n(hs_n[1]),
      .o_VSYNC_n(vs_n[1]), .o_CSYNC_n(cs_n[1]), .o_LINE_STB(stb[1]),
      .o_FRAMEPARITY(par[1]), .o_IRQ_n(irq_n[1]), .o_IRQ_OVR(ovr[1]));

   function automatic int hl(int i);
      return G[i].he - G[i].hs + 1;
   endfunction

   function automatic int vl(int i);
      return G[i].ve - G[i].vs + 1;
   endfunction

   // Number of line advances after nn pixel enables since reset.
   function automatic int advs(int i, int nn);
      int a;
      a = G[i].la - G[i].hs;
      return (nn >= a) ? (nn - a) / hl(i) + 1 : 0;
   endfunction

   function automatic bit adv_at(int i, int nn);
      return (nn > 0) && (nn % hl(i) == G[i].la - G[i].hs);
   endfunction

   function automatic int eh(int i);
      return G[i].hs + n % hl(i);
   endfunction

   function automatic int ev_n(int i, int nn);
      return G[i].vs + advs(i, nn) % vl(i);
   endfunction

   function automatic bit epar(int i);
      int b, k;
      b = G[i].vbon - G[i].vs;
      k = advs(i, n);
      return (k >= b) ? bit'(((k - b) / vl(i) + 1) & 1) : 1'b0;
   endfunction

   function automatic bit will_match(int i);
      if (!adv_at(i, n + 1)) return 1'b0;
      return ev_n(i, n + 1) == int'(irq_line[i]);
   endfunction

   task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                      input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s[%0d] n=%0d: got %0h, expected %0h", tag, inst, n, obs, expv);
      end
   endtask

   task automatic model_reset();
      n = 0;
      for (int i = 0; i < NI; i++) begin
         m_irq[i] = 1'b0;
         m_ovr[i] = 1'b0;
      end
   endtask

   task automatic model_step(input logic e_n, input logic a_n);
      if (e_n !== 1'b0) return;
      n++;
      for (int i = 0; i < NI; i++) begin
         bit match;
         match = irq_en && adv_at(i, n) && (ev_n(i, n) == int'(irq_line[i]));
         if (match) begin
            if (!a_n) m_ovr[i] = 1'b0;
            else if (m_irq[i]) m_ovr[i] = 1'b1;
            m_irq[i] = 1'b1;
         end else if (!a_n) begin
            m_irq[i] = 1'b0;
            m_ovr[i] = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         int h, v;
         bit hs_a, vs_a;
         h = eh(i);
         v = ev_n(i, n);
         hs_a = (h >= G[i].hson) && (h < G[i].hsoff);
         vs_a = (v >= G[i].vson) && (v < G[i].vsoff);
         chk("hcnt", i, hcnt[i], h);
         chk("vcnt", i, vcnt[i], v);
         chk("flip_h", i, fh[i], (h ^ (hflip ? 255 : 0)) & 255);
         chk("flip_v", i, fv[i], (v ^ (vflip ? 255 : 0)) & 255);
         chk("hblank_n", i, hb_n[i], h >= G[i].hbo);
         chk("vblank_n", i, vb_n[i], !((v >= G[i].vbon) || (v < G[i].vboff)));
         chk("hsync_n", i, hs_n[i], !hs_a);
         chk("vsync_n", i, vs_n[i], !vs_a);
         chk("csync_n", i, cs_n[i], vs_a ? hs_a : !hs_a);
         chk("line_stb", i, stb[i], adv_at(i, n));
         chk("parity", i, par[i], epar(i));
         chk("irq_n", i, irq_n[i], !m_irq[i]);
         chk("irq_ovr", i, ovr[i], m_ovr[i]);
      end
   endtask

   // Called at a negedge: drive, let one posedge happen, then compare at the next negedge.
   task automatic cyc(input logic e_n, input logic a_n);
      en_n  = e_n;
      ack_n = a_n;
      @(posedge clk);
      model_step(e_n, a_n);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      G[0] = '{128, 511, 176, 256, 176, 208, 248, 511, 496, 272, 248, 256};
      G[1] = '{480, 511, 488, 496, 488, 492, 480, 511, 506, 484, 480, 482};
      irq_line[0] = 9'd250;
      irq_line[1] = 9'd490;
      model_reset();
      repeat (3) @(negedge clk);
      check_all();
      rst_n = 1'b1;

      // Enable every second MCLK; no acks, so the small raster overruns on its second frame.
      irq_en = 1'b1;
      for (int k = 0; k < 4400; k++) cyc((k % 2) != 0, 1'b1);
      chk("irq_pending_dflt", 0, irq_n[0], 0);
      chk("ovr_second_match", 1, ovr[1], 1);

      // Random enables, flips, sparse acks and IRQ lines including some outside the raster.
      for (int k = 0; k < 8000; k++) begin
         if (k % 500 == 0) irq_line[1] = 9'($urandom_range(470, 511));
         if ($urandom % 8 == 0) hflip = ~hflip;
         if ($urandom % 8 == 0) vflip = ~vflip;
         cyc(1'($urandom % 2), ($urandom % 64 == 0) ? 1'b0 : 1'b1);
      end

      // Ack lands exactly on each match: IRQ stays low and overrun is cleared.
      irq_line[1] = 9'd500;
      for (int k = 0; k < 2200; k++) cyc(1'b0, will_match(1) ? 1'b0 : 1'b1);
      chk("irq_coincident_ack", 1, irq_n[1], 0);
      chk("ovr_coincident_ack", 1, ovr[1], 0);

      // Interrupt disabled: pending request is held, no new matches.
      irq_en = 1'b0;
      irq_line[1] = 9'd490;
      for (int k = 0; k < 2500; k++) cyc(1'b0, 1'b1);
      chk("irq_held_disabled", 1, irq_n[1], 0);
      chk("ovr_disabled", 1, ovr[1], 0);

      // Asynchronous reset between clock edges.
      hflip = 1'b0;
      vflip = 1'b0;
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      @(negedge clk);
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      irq_en = 1'b1;
      for (int k = 0; k < 600; k++) cyc(1'($urandom % 2), 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
